// File: rtl/pid_sequencer.sv
// PID front-end: latches one attitude sample, then computes P/I/D error terms
// for pitch, roll and yaw on a single shared arithmetic lane, one axis per cycle.
module pid_sequencer #(
  parameter int DW      = 24,
  parameter int I_LIMIT = 4194303
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] meas_pitch,
  input  logic [DW-1:0] meas_roll,
  input  logic [DW-1:0] meas_yaw,
  input  logic [DW-1:0] sp_pitch,
  input  logic [DW-1:0] sp_roll,
  input  logic [DW-1:0] sp_yaw,
  output logic [DW-1:0] pitch_error,
  output logic [DW-1:0] roll_error,
  output logic [DW-1:0] yaw_error,
  output logic [DW-1:0] i_pitch_error,
  output logic [DW-1:0] i_roll_error,
  output logic [DW-1:0] i_yaw_error,
  output logic [DW-1:0] d_pitch_error,
  output logic [DW-1:0] d_roll_error,
  output logic [DW-1:0] d_yaw_error,
  output logic          cal_pid_en,
  output logic [2:0]    i_sat,
  output logic [15:0]   sample_cnt
);

  typedef enum logic {IDLE, CALC} state_e;

  localparam logic signed [DW:0] ILIM_P = (DW+1)'(I_LIMIT);
  localparam logic signed [DW:0] ILIM_N = -ILIM_P;

  state_e state_q, state_d;
  logic [1:0] axis_q, axis_d;

  logic [2:0][DW-1:0] sp_q, sp_d;
  logic [2:0][DW-1:0] meas_q, meas_d;
  logic [2:0][DW-1:0] err_q, err_d;
  logic [2:0][DW-1:0] i_q, i_d;
  logic [2:0][DW-1:0] d_q, d_d;
  logic [2:0][DW-1:0] prev_q, prev_d;
  logic [2:0]         i_sat_q, i_sat_d;
  logic               cal_q, cal_d;
  logic               first_q, first_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [DW-1:0]      cur_sp, cur_meas, cur_i, cur_prev;
  logic signed [DW:0] e_wide, i_wide, d_wide;
  logic [DW-1:0]      e_new, i_new, d_new;
  logic               clamp_hi, clamp_lo;

  function automatic logic [DW-1:0] sat(input logic [DW:0] x);
    if (x[DW] != x[DW-1])
      return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return x[DW-1:0];
  endfunction

  // Shared arithmetic lane, operands muxed by the axis being computed
  always_comb begin
    cur_sp   = '0;
    cur_meas = '0;
    cur_i    = '0;
    cur_prev = '0;
    for (int unsigned a = 0; a < 3; a++) begin
      if (axis_q == 2'(a)) begin
        cur_sp   = sp_q[a];
        cur_meas = meas_q[a];
        cur_i    = i_q[a];
        cur_prev = prev_q[a];
      end
    end
    e_wide   = $signed({cur_sp[DW-1], cur_sp}) - $signed({cur_meas[DW-1], cur_meas});
    e_new    = sat(e_wide);
    i_wide   = $signed({cur_i[DW-1], cur_i}) + $signed({e_new[DW-1], e_new});
    clamp_hi = i_wide > ILIM_P;
    clamp_lo = i_wide < ILIM_N;
    i_new    = clamp_hi ? ILIM_P[DW-1:0] : (clamp_lo ? ILIM_N[DW-1:0] : i_wide[DW-1:0]);
    d_wide   = $signed({e_new[DW-1], e_new}) - $signed({cur_prev[DW-1], cur_prev});
    d_new    = first_q ? '0 : sat(d_wide);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      axis_q  <= '0;
      sp_q    <= '0;
      meas_q  <= '0;
      err_q   <= '0;
      i_q     <= '0;
      d_q     <= '0;
      prev_q  <= '0;
      i_sat_q <= '0;
      cal_q   <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      sp_q    <= sp_d;
      meas_q  <= meas_d;
      err_q   <= err_d;
      i_q     <= i_d;
      d_q     <= d_d;
      prev_q  <= prev_d;
      i_sat_q <= i_sat_d;
      cal_q   <= cal_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    if (!arm) begin
      state_d = IDLE;
      axis_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            state_d = CALC;
            axis_d  = '0;
          end
        end
        CALC: begin
          if (axis_q == 2'd2) begin
            state_d = IDLE;
            axis_d  = '0;
          end else begin
            axis_d = axis_q + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
          axis_d  = '0;
        end
      endcase
    end
  end

  // Disarm wins over everything except reset; sample_cnt survives a disarm
  always_comb begin
    sp_d    = sp_q;
    meas_d  = meas_q;
    err_d   = err_q;
    i_d     = i_q;
    d_d     = d_q;
    prev_d  = prev_q;
    i_sat_d = i_sat_q;
    cal_d   = 1'b0;
    first_d = first_q;
    cnt_d   = cnt_q;
    if (!arm) begin
      err_d   = '0;
      i_d     = '0;
      d_d     = '0;
      prev_d  = '0;
      i_sat_d = '0;
      first_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (s_valid) begin
        sp_d   = {sp_yaw, sp_roll, sp_pitch};
        meas_d = {meas_yaw, meas_roll, meas_pitch};
      end
    end else begin
      for (int unsigned a = 0; a < 3; a++) begin
        if (axis_q == 2'(a)) begin
          err_d[a]   = e_new;
          i_d[a]     = i_new;
          d_d[a]     = d_new;
          prev_d[a]  = e_new;
          i_sat_d[a] = clamp_hi | clamp_lo;
        end
      end
      if (axis_q == 2'd2) begin
        cal_d   = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        first_d = 1'b0;
      end
    end
  end

  assign s_ready       = (state_q == IDLE);
  assign pitch_error   = err_q[0];
  assign roll_error    = err_q[1];
  assign yaw_error     = err_q[2];
  assign i_pitch_error = i_q[0];
  assign i_roll_error  = i_q[1];
  assign i_yaw_error   = i_q[2];
  assign d_pitch_error = d_q[0];
  assign d_roll_error  = d_q[1];
  assign d_yaw_error   = d_q[2];
  assign cal_pid_en    = cal_q;
  assign i_sat         = i_sat_q;
  assign sample_cnt    = cnt_q;

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
Front-end controller for the quadcopter PID/motor-mix datapath. It accepts attitude samples (pitch/roll/yaw) and setpoints through a valid/ready handshake. For each axis in turn it computes the proportional error, the clamped integral and the derivative, using one shared arithmetic lane. When all nine error terms are stable it fires a one-cycle cal_pid_en strobe to the mixing stage. An arm input gates the loop and clears all controller state when deasserted.

Parameters:
DW, 24, width of all signed two's-complement attitude, setpoint and error values
I_LIMIT, 4194303, symmetric integral clamp magnitude (|i_*_error| <= I_LIMIT); must be < 2^(DW-1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
arm  input  1  1 = loop running; 0 = disarmed, state cleared, no strobes
s_valid  input  1  sample valid
s_ready  output  1  sample ready; high only in IDLE
meas_pitch / meas_roll / meas_yaw  input  DW each  measured attitude, signed
sp_pitch / sp_roll / sp_yaw  input  DW each  attitude setpoint, signed
pitch_error / roll_error / yaw_error  output  DW each  proportional error
i_pitch_error / i_roll_error / i_yaw_error  output  DW each  clamped integral
d_pitch_error / d_roll_error / d_yaw_error  output  DW each  derivative
cal_pid_en  output  1  one-cycle strobe: all nine error outputs valid
i_sat  output  3  {yaw,roll,pitch}: integral clamped on last computed sample
sample_cnt  output  16  count of strobes issued, wraps 65535 -> 0

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE; all error, i and d outputs = 0; prev_err[0..2] = 0; cal_pid_en=0; i_sat=0; sample_cnt=0; first=1.
- s_ready is combinational: (state==IDLE). Handshake occurs on an edge where s_valid && s_ready.
- IDLE: on handshake with arm=1, latch all six meas/sp inputs, set axis=0, go to CALC. Handshake with arm=0: sample consumed and dropped; stay in IDLE.
- CALC: one axis per cycle, in the order pitch (0), roll (1), yaw (2). At each edge, for the current axis:
  - e = sat(sp - meas)
  - i = clamp(i_old + e, -I_LIMIT, +I_LIMIT); i_sat[axis] = 1 if the clamp was active
  - d = first ? 0 : sat(e - prev_err[axis])
  - prev_err[axis] = e
- All sums are formed at DW+1 bits. sat() saturates to [-2^(DW-1), 2^(DW-1)-1].
- CALC at axis=2: update the yaw outputs, set cal_pid_en=1, sample_cnt+1, first=0, go to IDLE.
- Latency: handshake at edge E0; pitch outputs update at E1, roll at E2, yaw at E3. cal_pid_en is high during the cycle E3->E4 only. s_ready is high again after E3. Maximum throughput is 1 sample per 4 cycles.
- cal_pid_en is never high for two consecutive cycles. Outputs hold their values between strobes.
- arm=0 at any edge (IDLE or CALC) takes priority:
  - abort to IDLE
  - clear all nine outputs, prev_err, i_sat
  - set first=1
  - no strobe that edge
  - sample_cnt is retained
- arm=0 during the strobe cycle: the strobe still deasserts normally at the next edge.
- s_valid while busy is back-pressured and never lost; the upstream block must hold its data until ready.
- rst_n has priority over arm.

Test Plan:
- Reset, arm=1, one sample sp=(100,0,0), meas=(40,0,0) -> pitch_error=60, i_pitch=60, d_pitch=0; strobe exactly 4 cycles after handshake; sample_cnt=1.
- Second identical sample, then a third with meas_pitch=50 -> i_pitch 120 then 170; d_pitch 0 then -10.
- Integral clamp: with I_LIMIT=1000, feed error 600 three times -> i = 600, 1000, 1000; i_sat[0] = 0, 1, 1. Then error -300 -> i=700, i_sat[0]=0.
- Saturation: sp=0x7FFFFF, meas=0x800000 -> error=0x7FFFFF. Next sample sp=0x800000, meas=0x7FFFFF -> error=0x800000, d=0x800000 (saturated).
- Back-to-back s_valid held high -> s_ready low for 3 cycles per sample; strobes spaced exactly 4 cycles; no sample dropped; sample_cnt increments per strobe.
- Drop arm during roll calculation -> no strobe; all outputs 0 next cycle. Re-arm with sample error 5 -> d=0 (first), i=5.
